// File: rtl/ins_mem_loader_pkg.sv
// Shared constants, state encoding and address helper for the boot-time
// instruction memory loader.
package ins_mem_loader_pkg;

    localparam logic [31:0] INS_START_ADDRESS = 32'h0040_0000;
    localparam int          HEADER_BYTES      = 4;
    localparam int          BYTE_COUNT_W      = $clog2(HEADER_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } loader_state_t;

    // Byte address of instruction word 'index' relative to 'base'.
    function automatic logic [31:0] word_address(input logic [31:0] base,
                                                 input logic [31:0] index);
        return base + {index[29:0], 2'b00};
    endfunction

endpackage

// File: rtl/ins_mem_loader_byte_to_word.sv
// Little-endian byte-to-word assembler shared by header and payload phases.
// word/word_valid are combinational so the caller can register on the 4th-byte edge.
module ins_mem_loader_byte_to_word
    import ins_mem_loader_pkg::*;
(
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        clear,
    input  logic        take,
    input  logic [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [BYTE_COUNT_W-1:0] byte_count;
    logic [23:0]             shift_reg;

    // Only the three earlier bytes are stored; the 4th comes straight from in_data.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            byte_count <= '0;
            shift_reg  <= '0;
        end else if (clear) begin
            byte_count <= '0;
            shift_reg  <= '0;
        end else if (take) begin
            byte_count <= byte_count + 1'b1;
            shift_reg  <= {in_data, shift_reg[23:8]};
        end
    end

    assign word       = {in_data, shift_reg};
    assign word_valid = take && (byte_count == BYTE_COUNT_W'(HEADER_BYTES - 1));

endmodule

// File: rtl/ins_mem_loader.sv
// Boot-time loader: parses a word-count header, streams payload words into the
// instruction memory write port and keeps the core stalled while loading.
module ins_mem_loader
    import ins_mem_loader_pkg::*;
#(
    parameter logic [31:0] START_ADDRESS = INS_START_ADDRESS,
    parameter int          DEPTH_WORDS   = 1000
) (
    input  logic        SYS_clk,
    input  logic        SYS_reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_stall,
    output logic        done,
    output logic        error,
    output logic [31:0] checksum
);

    loader_state_t state, state_next;

    logic        take;
    logic        load_clear;
    logic        word_valid;
    logic [31:0] word;
    logic [31:0] word_count;
    logic [31:0] index;
    logic        header_bad;
    logic        last_word;

    assign in_ready   = (state == ST_HEADER) || (state == ST_PAYLOAD);
    assign take       = in_valid && in_ready;
    assign cpu_stall  = (state == ST_HEADER) || (state == ST_PAYLOAD) || (state == ST_FLUSH);
    assign done       = (state == ST_DONE);
    assign error      = (state == ST_ERROR);
    assign header_bad = (word == 32'd0) || (word > 32'(DEPTH_WORDS));
    assign last_word  = (index == word_count - 32'd1);

    ins_mem_loader_byte_to_word u_byte_to_word (
        .SYS_clk    (SYS_clk),
        .SYS_reset  (SYS_reset),
        .clear      (load_clear),
        .take       (take),
        .in_data    (in_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // start is only honoured while no load is in flight.
    always_comb begin
        state_next = state;
        load_clear = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_HEADER;
                    load_clear = 1'b1;
                end
            end
            ST_HEADER: begin
                if (word_valid) begin
                    state_next = header_bad ? ST_ERROR : ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (word_valid && last_word) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Write port, index and checksum all update on the edge taking a word's 4th byte.
    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            checksum   <= '0;
            index      <= '0;
            word_count <= '0;
        end else begin
            wr_en <= 1'b0;
            if (load_clear) begin
                checksum   <= '0;
                index      <= '0;
                word_count <= '0;
            end else if (state == ST_HEADER && word_valid) begin
                word_count <= word;
            end else if (state == ST_PAYLOAD && word_valid) begin
                wr_en    <= 1'b1;
                wr_data  <= word;
                wr_addr  <= word_address(START_ADDRESS, index);
                checksum <= checksum + word;
                index    <= index + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Self-checking bench for ins_mem_loader: table-driven loads with random payloads,
// a stream-level reference model, and hand-written reset/boundary sequences.
module tb_ins_mem_loader;

    localparam logic [31:0] START = 32'h0040_0000;
    localparam int          DEPTH = 1000;

    logic        SYS_clk = 1'b0;
    logic        SYS_reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_stall;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    int tests = 0;
    int fails = 0;

    always #5 SYS_clk = ~SYS_clk;

    ins_mem_loader #(.START_ADDRESS(START), .DEPTH_WORDS(DEPTH)) dut (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .cpu_stall (cpu_stall),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    // Observed write-port activity, sampled on the falling edge.
    int          cycle = 0;
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [31:0] obs_sum[$];
    int          last_wr_cycle = 0;
    int          done_cycle = 0;
    int          done_rises = 0;
    logic        prev_done = 1'b0;

    always @(negedge SYS_clk) begin
        cycle++;
        if (wr_en === 1'b1) begin
            obs_addr.push_back(wr_addr);
            obs_data.push_back(wr_data);
            obs_sum.push_back(checksum);
            last_wr_cycle = cycle;
        end
        if (done === 1'b1 && prev_done !== 1'b1) begin
            done_rises++;
            done_cycle = cycle;
        end
        prev_done = done;
    end

    // Reference model: expected writes derived from the byte stream itself.
    logic [7:0]  stream[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] exp_sum[$];
    bit          exp_err;

    function automatic void build_model(input logic [31:0] hdr);
        logic [31:0] sum;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_sum.delete();
        exp_err = (hdr == 32'd0) || (hdr > 32'(DEPTH));
        sum = 32'd0;
        if (!exp_err) begin
            for (int k = 0; k < int'(hdr); k++) begin
                w = {stream[4 + 4*k + 3], stream[4 + 4*k + 2], stream[4 + 4*k + 1], stream[4 + 4*k]};
                sum = sum + w;
                exp_addr.push_back(START + 32'(k) * 32'd4);
                exp_data.push_back(w);
                exp_sum.push_back(sum);
            end
        end
    endfunction

    function automatic void make_stream(input logic [31:0] hdr);
        stream.delete();
        for (int i = 0; i < 4; i++) stream.push_back(hdr[8*i +: 8]);
        if (hdr != 32'd0 && hdr <= 32'(DEPTH)) begin
            for (int i = 0; i < 4 * int'(hdr); i++) stream.push_back(8'($urandom));
        end
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_monitor();
        obs_addr.delete();
        obs_data.delete();
        obs_sum.delete();
        done_rises = 0;
        last_wr_cycle = 0;
        done_cycle = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge SYS_clk);
        start = 1'b0;
    endtask

    // Offers one byte and returns at the falling edge after it was accepted.
    task automatic send_byte(input logic [7:0] b, input bit gap, input bit with_start);
        int budget;
        budget = 20;
        if (gap) begin
            in_valid = 1'b0;
            @(negedge SYS_clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        start    = with_start;
        while (in_ready !== 1'b1 && budget > 0) begin
            @(negedge SYS_clk);
            budget--;
        end
        if (in_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("[TB] FAIL in_ready_timeout: got 0 expected 1");
        end
        @(negedge SYS_clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    // gap_mode: 0 back-to-back, 1 gap before every byte, 2 random gaps.
    task automatic apply_stimulus(input int gap_mode, input bit mid_start);
        int  budget;
        bit  gap;
        clear_monitor();
        pulse_start();
        for (int i = 0; i < stream.size(); i++) begin
            gap = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 1) == 1);
            send_byte(stream[i], gap, mid_start && i == 5);
            if (i == 3) check_output("error_after_header", 32'(error), 32'(exp_err));
        end
        budget = 10;
        while (done !== 1'b1 && error !== 1'b1 && budget > 0) begin
            @(negedge SYS_clk);
            budget--;
        end
        if (done !== 1'b1 && error !== 1'b1) begin
            tests++;
            fails++;
            $display("[TB] FAIL load_timeout: got done=%0b error=%0b expected completion", done, error);
        end
        repeat (3) @(negedge SYS_clk);
    endtask

    task automatic compare_load(input string name);
        check_output({name, "_nwrites"}, 32'(obs_data.size()), 32'(exp_data.size()));
        for (int k = 0; k < obs_data.size() && k < exp_data.size(); k++) begin
            check_output({name, "_addr"}, obs_addr[k], exp_addr[k]);
            check_output({name, "_data"}, obs_data[k], exp_data[k]);
            check_output({name, "_sum"},  obs_sum[k],  exp_sum[k]);
        end
        check_output({name, "_done"},      32'(done),      32'(!exp_err));
        check_output({name, "_error"},     32'(error),     32'(exp_err));
        check_output({name, "_cpu_stall"}, 32'(cpu_stall), 32'd0);
        if (exp_err) begin
            check_output({name, "_in_ready"}, 32'(in_ready), 32'd0);
        end else begin
            check_output({name, "_done_rises"}, 32'(done_rises), 32'd1);
            check_output({name, "_done_timing"}, 32'(done_cycle), 32'(last_wr_cycle + 1));
        end
    endtask

    typedef struct {
        logic [31:0] hdr;
        int          gap_mode;
        bit          mid_start;
        bit          exp_error;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{32'd2,          0, 1'b0, 1'b0};
        vecs[1] = '{32'd0,          0, 1'b0, 1'b1};
        vecs[2] = '{32'd1,          0, 1'b0, 1'b0};
        vecs[3] = '{32'd1001,       0, 1'b0, 1'b1};
        vecs[4] = '{32'd1,          1, 1'b0, 1'b0};
        vecs[5] = '{32'd3,          0, 1'b1, 1'b0};
        vecs[6] = '{32'hFFFF_FFFF,  2, 1'b0, 1'b1};
        vecs[7] = '{32'd6,          2, 1'b1, 1'b0};
        vecs[8] = '{32'd1000,       0, 1'b0, 1'b0};

        SYS_reset = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        repeat (2) @(negedge SYS_clk);
        check_output("rst_in_ready",  32'(in_ready),  32'd0);
        check_output("rst_wr_en",     32'(wr_en),     32'd0);
        check_output("rst_wr_addr",   wr_addr,        32'd0);
        check_output("rst_wr_data",   wr_data,        32'd0);
        check_output("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        check_output("rst_done",      32'(done),      32'd0);
        check_output("rst_error",     32'(error),     32'd0);
        check_output("rst_checksum",  checksum,       32'd0);
        SYS_reset = 1'b0;
        @(negedge SYS_clk);

        // Reference two-word program with fixed expected results.
        stream = '{8'h02, 8'h00, 8'h00, 8'h00,
                   8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        build_model(32'd2);
        apply_stimulus(0, 1'b0);
        check_output("fixed_nwrites", 32'(obs_data.size()), 32'd2);
        if (obs_data.size() >= 2) begin
            check_output("fixed_addr0", obs_addr[0], START);
            check_output("fixed_data0", obs_data[0], 32'h0000_0013);
            check_output("fixed_addr1", obs_addr[1], START + 32'd4);
            check_output("fixed_data1", obs_data[1], 32'h0010_0093);
            check_output("fixed_sum",   obs_sum[1],  32'h0010_00A6);
        end
        check_output("fixed_checksum_hold", checksum, 32'h0010_00A6);
        compare_load("fixed");

        // Table of header/gap/start patterns with random payloads.
        foreach (vecs[v]) begin
            make_stream(vecs[v].hdr);
            build_model(vecs[v].hdr);
            apply_stimulus(vecs[v].gap_mode, vecs[v].mid_start);
            check_output($sformatf("vec%0d_error_table", v), 32'(error), 32'(vecs[v].exp_error));
            compare_load($sformatf("vec%0d", v));
            if (vecs[v].hdr == 32'd1000 && obs_addr.size() > 0) begin
                check_output("vec_last_addr", obs_addr[$], START + 32'h0000_0F9C);
            end
        end

        // Reset between the 2nd and 3rd payload bytes.
        make_stream(32'd2);
        clear_monitor();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(stream[i], 1'b0, 1'b0);
        #2;
        SYS_reset = 1'b1;
        #1;
        check_output("abort_in_ready",  32'(in_ready),  32'd0);
        check_output("abort_wr_en",     32'(wr_en),     32'd0);
        check_output("abort_wr_addr",   wr_addr,        32'd0);
        check_output("abort_wr_data",   wr_data,        32'd0);
        check_output("abort_cpu_stall", 32'(cpu_stall), 32'd0);
        check_output("abort_checksum",  checksum,       32'd0);
        repeat (2) @(negedge SYS_clk);
        SYS_reset = 1'b0;
        @(negedge SYS_clk);
        check_output("abort_no_write", 32'(obs_data.size()), 32'd0);

        // Full load after the abort must succeed.
        make_stream(32'd4);
        build_model(32'd4);
        apply_stimulus(0, 1'b0);
        compare_load("after_abort");

        // Randomized loads, mixing valid and invalid headers.
        for (int r = 0; r < 12; r++) begin
            logic [31:0] hdr;
            case ($urandom_range(0, 5))
                0:       hdr = 32'd0;
                1:       hdr = 32'(DEPTH) + 32'($urandom_range(1, 5000));
                default: hdr = 32'($urandom_range(1, 10));
            endcase
            make_stream(hdr);
            build_model(hdr);
            apply_stimulus(2, $urandom_range(0, 1) == 1);
            compare_load($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
